// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and FSM encoding for the fetch stage
//
// Purpose: FSM state type, default datapath width, default reset PC and the
//          canonical NOP encoding used by benches.
package fetch_unit_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// rtl/fetch_unit_pc_reg.sv - PC register with one-entry pending update and alignment check
//
// Purpose: holds the PC, applies sequential/redirect updates immediately when
//          no fetch is in flight, otherwise buffers the last update until the
//          fetch retires.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   pc_write        commit a next-PC this cycle
//   redirect        next PC = redirect_pc (else pc + 4)
//   redirect_pc     branch/jump target
//   busy            a fetch is in flight (REQ or VALID)
//   retire          this edge is the VALID->IDLE transition
//   pc              current PC
//   pc_plus4        pc + 4, combinational, wraps
//   pend_valid      an update is buffered
//   fault_strobe    misaligned redirect seen this cycle
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            busy,
  input  logic            retire,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pend_valid,
  output logic            fault_strobe
);

  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            write_ok;

  assign pc_plus4     = pc + {{(XLEN-3){1'b0}}, 3'd4};
  assign target       = redirect ? redirect_pc : pc_plus4;
  // Only redirect targets can be misaligned; pc+4 preserves alignment.
  assign misaligned   = redirect && (redirect_pc[1:0] != 2'b00);
  assign fault_strobe = pc_write && misaligned;
  assign write_ok     = pc_write && !misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      pend_pc    <= '0;
      pend_valid <= 1'b0;
    end else if (!busy) begin
      if (write_ok) pc <= target;
    end else if (retire) begin
      // A write landing on the retire edge is the newest, so it beats the buffer.
      pend_valid <= 1'b0;
      if (write_ok)        pc <= target;
      else if (pend_valid) pc <= pend_pc;
    end else if (write_ok) begin
      pend_valid <= 1'b1;
      pend_pc    <= target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - multicycle instruction fetch stage with instruction register
//
// Purpose: issues word fetches at PC over a req/ready handshake, latches the
//          returned word into INSTR and pulses IRWrite for the decoder.
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   FETCH_EN                 start a fetch at PC (sampled in IDLE only)
//   PC_WRITE/REDIRECT/REDIRECT_PC  next-PC commit from control unit
//   IMEM_REQ/IMEM_ADDR       fetch request and address
//   IMEM_READY/IMEM_RDATA    memory accept + returned word
//   INSTR/INSTR_PC/IRWrite   instruction register, its PC, new-word pulse
//   PC/PC_PLUS4              current PC and PC+4
//   FAULT                    sticky misaligned-redirect flag
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = XLEN_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            FETCH_EN,
  input  logic            PC_WRITE,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_READY,
  input  logic [XLEN-1:0] IMEM_RDATA,
  output logic [XLEN-1:0] INSTR,
  output logic            IRWrite,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] INSTR_PC,
  output logic [XLEN-1:0] PC_PLUS4,
  output logic            FAULT
);

  fetch_state_t state_q, state_d;
  logic         fetch_defer_q, fetch_defer_d;
  logic         pend_valid;
  logic         fault_strobe;
  logic         start;

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC[XLEN-1:0])
  ) u_pc_reg (
    .clk          (CLK),
    .rst          (RST),
    .pc_write     (PC_WRITE),
    .redirect     (REDIRECT),
    .redirect_pc  (REDIRECT_PC),
    .busy         (state_q != ST_IDLE),
    .retire       (state_q == ST_VALID),
    .pc           (PC),
    .pc_plus4     (PC_PLUS4),
    .pend_valid   (pend_valid),
    .fault_strobe (fault_strobe)
  );

  // A PC write in IDLE wins over a fetch request: the fetch is deferred one
  // cycle so it is issued from the updated PC.
  assign start = (FETCH_EN || fetch_defer_q) && !PC_WRITE && !FAULT
                 && !fault_strobe && !pend_valid;

  always_comb begin
    state_d       = state_q;
    fetch_defer_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        fetch_defer_d = (FETCH_EN || fetch_defer_q) && PC_WRITE;
        if (start) state_d = ST_REQ;
      end
      ST_REQ:   if (IMEM_READY) state_d = ST_VALID;
      ST_VALID: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      fetch_defer_q <= 1'b0;
      INSTR         <= '0;
      INSTR_PC      <= '0;
      FAULT         <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_defer_q <= fetch_defer_d;
      if (fault_strobe) FAULT <= 1'b1;
      if (state_q == ST_REQ && IMEM_READY) begin
        INSTR    <= IMEM_RDATA;
        INSTR_PC <= PC;
      end
    end
  end

  // Decoded straight from the state register so reset drops them at once.
  assign IMEM_REQ  = (state_q == ST_REQ);
  assign IMEM_ADDR = PC;
  assign IRWrite   = (state_q == ST_VALID);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        CLK, RST;
  logic        FETCH_EN, PC_WRITE, REDIRECT, IMEM_READY;
  logic [31:0] REDIRECT_PC, IMEM_RDATA;
  logic        IMEM_REQ, IRWrite, FAULT;
  logic [31:0] IMEM_ADDR, INSTR, PC, INSTR_PC, PC_PLUS4;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  int nvec = 0;
  int nerr = 0;

  fetch_unit #(.RESET_PC(32'h0), .XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .FETCH_EN(FETCH_EN), .PC_WRITE(PC_WRITE),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .IMEM_REQ(IMEM_REQ),
    .IMEM_ADDR(IMEM_ADDR), .IMEM_READY(IMEM_READY), .IMEM_RDATA(IMEM_RDATA),
    .INSTR(INSTR), .IRWrite(IRWrite), .PC(PC), .INSTR_PC(INSTR_PC),
    .PC_PLUS4(PC_PLUS4), .FAULT(FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    FETCH_EN = 0; PC_WRITE = 0; REDIRECT = 0; REDIRECT_PC = 0;
    IMEM_READY = 0; IMEM_RDATA = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] addr);
    PC_WRITE = 1; REDIRECT = 1; REDIRECT_PC = addr;
    cyc();
    PC_WRITE = 0; REDIRECT = 0;
  endtask

  // Wait (bounded) for IRWrite, then pop the scoreboard and compare.
  task automatic collect(input string name);
    exp_t e;
    int   n = 0;
    while (IRWrite !== 1'b1 && n < 8) begin
      cyc();
      n++;
    end
    nvec++;
    if (IRWrite !== 1'b1) begin
      nerr++;
      $display("FAIL %s_timeout: IRWrite never rose, got %b expected 1", name, IRWrite);
    end else if (sb.size() == 0) begin
      nerr++;
      $display("FAIL %s_sb: IRWrite with empty scoreboard, got 1 expected 0", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_instr"}, INSTR, e.instr);
      chk({name, "_instr_pc"}, INSTR_PC, e.pc);
    end
  endtask

  task automatic do_fetch(input string name, input logic [31:0] word,
                          input int delay, input logic [31:0] exp_pc);
    sb.push_back('{instr: word, pc: exp_pc});
    FETCH_EN = 1;
    cyc();
    FETCH_EN = 0;
    chk({name, "_req"}, {31'b0, IMEM_REQ}, 32'd1);
    chk({name, "_addr"}, IMEM_ADDR, exp_pc);
    for (int i = 0; i < delay; i++) begin
      cyc();
      chk({name, "_req_held"}, {31'b0, IMEM_REQ}, 32'd1);
      chk({name, "_addr_held"}, IMEM_ADDR, exp_pc);
      chk({name, "_irw_early"}, {31'b0, IRWrite}, 32'd0);
    end
    IMEM_READY = 1; IMEM_RDATA = word;
    cyc();
    IMEM_READY = 0; IMEM_RDATA = 32'hDEAD_BEEF;
    chk({name, "_irw_latency"}, {31'b0, IRWrite}, 32'd1);
    collect(name);
    cyc();
    chk({name, "_irw_pulse"}, {31'b0, IRWrite}, 32'd0);
  endtask

  task automatic test_reset();
    apply_reset();
    chk("rst_pc", PC, 32'h0);
    chk("rst_req", {31'b0, IMEM_REQ}, 32'd0);
    chk("rst_irw", {31'b0, IRWrite}, 32'd0);
    chk("rst_instr", INSTR, 32'h0);
    chk("rst_instr_pc", INSTR_PC, 32'h0);
    chk("rst_fault", {31'b0, FAULT}, 32'd0);
  endtask

  task automatic test_first_fetch();
    do_fetch("first", 32'h0050_0093, 0, 32'h0);
    chk("first_pc_kept", PC, 32'h0);
  endtask

  task automatic test_stall();
    do_fetch("stall", NOP_INSTR, 3, 32'h0);
  endtask

  task automatic test_pc_update();
    set_pc(32'h100);
    chk("upd_redirect", PC, 32'h100);
    chk("upd_plus4", PC_PLUS4, 32'h104);
    PC_WRITE = 1; REDIRECT = 0;
    cyc();
    PC_WRITE = 0;
    chk("upd_seq", PC, 32'h104);
    set_pc(32'h200);
    chk("upd_redirect2", PC, 32'h200);
  endtask

  task automatic test_pending();
    set_pc(32'h104);
    sb.push_back('{instr: 32'h0011_0113, pc: 32'h104});
    FETCH_EN = 1;
    cyc();
    FETCH_EN = 0;
    PC_WRITE = 1; REDIRECT = 1; REDIRECT_PC = 32'h300;
    cyc();
    PC_WRITE = 0; REDIRECT = 0;
    chk("pend_pc_held", PC, 32'h104);
    chk("pend_addr_held", IMEM_ADDR, 32'h104);
    IMEM_READY = 1; IMEM_RDATA = 32'h0011_0113;
    cyc();
    IMEM_READY = 0;
    collect("pend");
    chk("pend_pc_in_valid", PC, 32'h104);
    cyc();
    chk("pend_applied", PC, 32'h300);
  endtask

  task automatic test_back_to_back();
    // Fetch request together with a sequential write: PC moves first.
    FETCH_EN = 1; PC_WRITE = 1; REDIRECT = 0;
    cyc();
    PC_WRITE = 0;
    chk("b2b_pc_first", PC, 32'h304);
    chk("b2b_idle_one", {31'b0, IMEM_REQ}, 32'd0);
    cyc();
    FETCH_EN = 0;
    chk("b2b_req", {31'b0, IMEM_REQ}, 32'd1);
    chk("b2b_addr", IMEM_ADDR, 32'h304);
    sb.push_back('{instr: 32'h00A0_0513, pc: 32'h304});
    IMEM_READY = 1; IMEM_RDATA = 32'h00A0_0513;
    cyc();
    IMEM_READY = 0;
    collect("b2b");
    cyc();
    do_fetch("b2b_next", 32'h0000_0073, 1, 32'h304);
  endtask

  task automatic test_wrap();
    set_pc(32'hFFFF_FFFC);
    chk("wrap_plus4", PC_PLUS4, 32'h0);
    PC_WRITE = 1; REDIRECT = 0;
    cyc();
    PC_WRITE = 0;
    chk("wrap_pc", PC, 32'h0);
  endtask

  task automatic test_fault();
    set_pc(32'h200);
    PC_WRITE = 1; REDIRECT = 1; REDIRECT_PC = 32'h202;
    cyc();
    PC_WRITE = 0; REDIRECT = 0;
    chk("fault_set", {31'b0, FAULT}, 32'd1);
    chk("fault_pc_kept", PC, 32'h200);
    FETCH_EN = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("fault_blocks", {31'b0, IMEM_REQ}, 32'd0);
      chk("fault_sticky", {31'b0, FAULT}, 32'd1);
    end
    FETCH_EN = 0;
    apply_reset();
    chk("fault_cleared", {31'b0, FAULT}, 32'd0);
  endtask

  task automatic test_reset_mid_req();
    set_pc(32'h40);
    FETCH_EN = 1;
    cyc();
    FETCH_EN = 0;
    chk("midrst_req", {31'b0, IMEM_REQ}, 32'd1);
    PC_WRITE = 1; REDIRECT = 1; REDIRECT_PC = 32'h500;
    cyc();
    PC_WRITE = 0; REDIRECT = 0;
    #2 RST = 1'b1;
    #1;
    chk("midrst_req_drop", {31'b0, IMEM_REQ}, 32'd0);
    chk("midrst_pc", PC, 32'h0);
    @(posedge CLK);
    #1 RST = 1'b0;
    cyc();
    cyc();
    chk("midrst_no_pending", PC, 32'h0);
    chk("midrst_idle", {31'b0, IMEM_REQ}, 32'd0);
    chk("midrst_irw", {31'b0, IRWrite}, 32'd0);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_pc_update();
    test_pending();
    test_back_to_back();
    test_wrap();
    test_fault();
    test_reset_mid_req();
    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
